// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall scheduler for the five-stage pipeline: drives buffer enables/flushes,
// resolves load-use, taken-branch and multi-cycle memory hazards, and counts stall/flush events.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        exmem_branch,
    input  logic        exmem_zf,
    input  logic        exmem_mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        pc_src,
    output logic [1:0]  state,
    output logic        err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] ERR      = 2'b10;
    localparam logic [7:0] WAIT_LIMIT = WAIT_MAX[7:0];

    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic [1:0] state_nxt;
    logic       err_nxt;
    logic       flush_inc;
    logic       mem_stall;
    logic       branch_taken;
    logic       load_use;

    assign mem_stall    = exmem_mem_req & ~mem_ready;
    assign branch_taken = exmem_branch & exmem_zf;
    assign load_use     = idex_mem_read && (idex_rt != 5'd0) &&
                          ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Reset is folded into the Mealy outputs so the buffers are cleared while rst is held.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_src      = 1'b0;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        err_nxt     = err;
        flush_inc   = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        state_nxt   = MEM_WAIT;
                        wait_nxt    = 8'd1;
                    end else if (branch_taken) begin
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Branch and load-use inputs are stale while the pipe is frozen, so ignore them.
                    if (mem_ready) begin
                        state_nxt = RUN;
                        wait_nxt  = 8'd0;
                    end else begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        if (wait_cnt == WAIT_LIMIT) begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            wait_nxt = wait_cnt + 8'd1;
                        end
                    end
                end
                ERR: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                    wait_nxt  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            err       <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err      <= err_nxt;
            if (!pc_en && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_inc && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected control vectors are queued as stimulus
// is driven and popped when the Mealy outputs are sampled mid-cycle.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        exmem_branch;
    logic        exmem_zf;
    logic        exmem_mem_req;
    logic        mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        pc_src;
    logic [1:0]  state;
    logic        err;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int tests  = 0;
    int failed = 0;
    logic [11:0] sb[$];
    logic [11:0] got;
    logic [11:0] want;
    logic [11:0] obs;

    pipe_hazard_ctrl #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_branch(exmem_branch), .exmem_zf(exmem_zf),
        .exmem_mem_req(exmem_mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_src(pc_src), .state(state), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign obs = {pc_en, ifid_en, idex_en, exmem_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush,
                  pc_src, state, err};

    function automatic logic [11:0] ev(input logic [3:0] en, input logic [3:0] fl,
                                       input logic ps, input logic [1:0] st, input logic er);
        return {en, fl, ps, st, er};
    endfunction

    // Expected control vectors: {enables PC..EXMEM, flushes IFID..MEMWB, pc_src, state, err}
    localparam logic [11:0] DEF  = {4'b1111, 4'b0000, 1'b0, 2'b00, 1'b0};
    localparam logic [11:0] RSTV = {4'b0000, 4'b1111, 1'b0, 2'b00, 1'b0};
    localparam logic [11:0] LU   = {4'b0011, 4'b0100, 1'b0, 2'b00, 1'b0};
    localparam logic [11:0] BR   = {4'b1111, 4'b1110, 1'b1, 2'b00, 1'b0};
    localparam logic [11:0] ERRV = {4'b0000, 4'b0000, 1'b0, 2'b10, 1'b1};

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] frt, input logic br, input logic zf,
                         input logic req, input logic rdy, input logic [11:0] exp_v);
        @(negedge clk);
        idex_mem_read = mr;
        idex_rt       = rt;
        ifid_rs       = rs;
        ifid_rt       = frt;
        exmem_branch  = br;
        exmem_zf      = zf;
        exmem_mem_req = req;
        mem_ready     = rdy;
        sb.push_back(exp_v);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; ifid_rt = 5'd2;
        exmem_branch = 1'b1; exmem_zf = 1'b1; exmem_mem_req = 1'b1; mem_ready = 1'b0;
        #2 rst = 1'b1;
        sb.push_back(RSTV);
        #1;
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL reset_outputs: got %b want %b", got, want); end
        @(negedge clk); #1;
        tests++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || state !== 2'b00) begin
            failed++;
            $display("[TB] FAIL reset_regs: got stall=%0d flush=%0d state=%b want 0 0 00", stall_cnt, flush_cnt, state);
        end
        idex_mem_read = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        exmem_branch = 1'b0; exmem_zf = 1'b0; exmem_mem_req = 1'b0; mem_ready = 1'b0;
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL reset_release: got %b want %b", got, want); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL lu_rs_match: got %b want %b", got, want); end
        drive(1'b0, 5'd0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL lu_clears: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'd1) begin failed++; $display("[TB] FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
        drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL lu_rt_match: got %b want %b", got, want); end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL lu_r0_ignored: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'd2) begin failed++; $display("[TB] FAIL lu_stall_cnt2: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_branch();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, BR);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL br_over_lu: got %b want %b", got, want); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL br_not_taken: got %b want %b", got, want); end
        tests++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
            failed++;
            $display("[TB] FAIL br_counters: got flush=%0d stall=%0d want 1 2", flush_cnt, stall_cnt);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL br_zf_only: got %b want %b", got, want); end
    endtask

    task automatic test_mem_wait();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0));
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL mw_enter: got %b want %b", got, want); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b01, 1'b0));
            got = obs; want = sb.pop_front(); tests++;
            if (got !== want) begin failed++; $display("[TB] FAIL mw_hold%0d: got %b want %b", i, got, want); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ev(4'b1111, 4'b0000, 1'b0, 2'b01, 1'b0));
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL mw_release: got %b want %b", got, want); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL mw_back_run: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd1) begin
            failed++;
            $display("[TB] FAIL mw_counters: got stall=%0d flush=%0d want 5 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0));
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL to_start: got %b want %b", got, want); end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b01, 1'b0));
            got = obs; want = sb.pop_front(); tests++;
            if (got !== want) begin failed++; $display("[TB] FAIL to_wait%0d: got %b want %b", i, got, want); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERRV);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL to_err: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'd10) begin failed++; $display("[TB] FAIL to_stall_cnt: got %0d want 10", stall_cnt); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, ERRV);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL to_err_sticky: got %b want %b", got, want); end
    endtask

    task automatic test_saturation();
        repeat (65600) @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ERRV);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL sat_still_err: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'hFFFF) begin failed++; $display("[TB] FAIL sat_stall_cnt: got %h want ffff", stall_cnt); end
        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (stall_cnt !== 16'hFFFF) begin failed++; $display("[TB] FAIL sat_no_wrap: got %h want ffff", stall_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        sb.push_back(RSTV);
        #1;
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL arst_from_err: got %b want %b", got, want); end
        tests++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failed++;
            $display("[TB] FAIL arst_counters: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        end
        exmem_mem_req = 1'b0; mem_ready = 1'b0;
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0));
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL arst_wait_enter: got %b want %b", got, want); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ev(4'b0000, 4'b0001, 1'b0, 2'b01, 1'b0));
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL arst_in_wait: got %b want %b", got, want); end
        #1 rst = 1'b1;
        sb.push_back(RSTV);
        #1;
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL arst_mid_wait: got %b want %b", got, want); end
        exmem_mem_req = 1'b0;
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
        got = obs; want = sb.pop_front(); tests++;
        if (got !== want) begin failed++; $display("[TB] FAIL arst_resume: got %b want %b", got, want); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall scheduler for the five-stage pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves load-use hazards, taken branches resolved in EX/MEM, and multi-cycle data-memory accesses, and it counts stall and flush events for debug. The buffers apply flush with priority over enable: a flushed buffer loads all-zero control, which is a bubble.

## Interface
Parameters:
- WAIT_MAX, 8: maximum cycles spent in MEM_WAIT before the error state. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- idex_mem_read  in  1  M[1] (MemRead) of the ID/EX stage
- idex_rt  in  5  destination rt of the ID/EX stage
- ifid_rs  in  5  rs field of the IF/ID instruction
- ifid_rt  in  5  rt field of the IF/ID instruction
- exmem_branch  in  1  registered M[2] (Branch) of EX/MEM
- exmem_zf  in  1  registered ZF of EX/MEM
- exmem_mem_req  in  1  registered M[1] | M[0] of EX/MEM
- mem_ready  in  1  data memory has completed the current access
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble inserts
- pc_src  out  1  1 selects the EX/MEM adder (branch target) as next PC
- state  out  2  RUN=00, MEM_WAIT=01, ERR=10
- err  out  1  sticky memory-timeout flag
- stall_cnt  out  16  cycles with pc_en=0, saturating
- flush_cnt  out  16  taken-branch events, saturating

## Operation
- Outputs are Mealy: combinational from state and current inputs. Registers hold state, wait_cnt (8b), stall_cnt, flush_cnt and err.
- Default outputs: every enable = 1, every flush = 0, pc_src = 0.
- While rst = 1:
  - all enables = 0 and all flushes = 1, so the pipeline is cleared.
  - state = RUN, wait_cnt = 0, counters = 0, err = 0.
- RUN, conditions evaluated in priority order:
  1. Memory wait: exmem_mem_req=1 and mem_ready=0.
     - Outputs: pc_en, ifid_en, idex_en and exmem_en = 0; memwb_flush = 1.
     - Next state: MEM_WAIT, with wait_cnt ← 1.
  2. Taken branch: exmem_branch=1 and exmem_zf=1.
     - Outputs: pc_src = 1; ifid_flush, idex_flush and exmem_flush = 1.
     - Enables stay 1. flush_cnt is incremented. State stays RUN.
  3. Load-use hazard: idex_mem_read=1, idex_rt≠0, and idex_rt equals ifid_rs or ifid_rt.
     - Outputs: pc_en = 0, ifid_en = 0, idex_flush = 1. State stays RUN.
- MEM_WAIT:
  - If mem_ready=1:
    - Outputs take their defaults; the stalled pipeline advances this cycle.
    - Next state: RUN, with wait_cnt ← 0.
  - If mem_ready=0:
    - Outputs are the same as the RUN memory-wait case.
    - If wait_cnt = WAIT_MAX: next state ERR, and err ← 1.
    - Otherwise: wait_cnt ← wait_cnt + 1.
  - Branch and load-use detection are suppressed in MEM_WAIT.
- ERR:
  - All enables = 0 and all flushes = 0, so the pipeline is frozen for inspection.
  - err = 1. Only rst exits ERR.
- Counters:
  - stall_cnt increments in every non-reset cycle with pc_en=0.
  - Both counters saturate at 16'hFFFF, do not wrap, and are cleared only by rst.
- Simultaneous events:
  - Memory wait wins over branch and over load-use.
  - Branch wins over load-use, because the flush removes the dependent instruction.

## Timing
- Hazard response has zero latency: controls are valid in the same cycle the inputs are presented, before the next clk edge.
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in EX/MEM and detection clears naturally.
- A taken branch costs 3 flushed slots (IF/ID, ID/EX, EX/MEM) and updates the PC on the same edge.
- A memory access completing after k wait cycles costs k stall cycles.
- The timeout fires on the edge following the cycle where wait_cnt = WAIT_MAX. ERR is visible WAIT_MAX+1 cycles after the stall began.
- rst assertion mid-wait returns the block to RUN immediately and asynchronously.

## Test plan
- Reset: assert rst with arbitrary inputs → all flushes 1, all enables 0, state=00, counters=0. Deassert → defaults.
- Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- Branch: exmem_branch=1, exmem_zf=1 while a load-use hazard is also present → pc_src=1, three flushes, pc_en=1, flush_cnt=1. With exmem_zf=0 → no flush.
- Memory wait: exmem_mem_req=1, mem_ready low for 3 cycles then high → 3 cycles of stall with memwb_flush=1, release on the 4th cycle, stall_cnt=3, state back to 00.
- Timeout: WAIT_MAX=4, mem_ready held 0 → state=10 and err=1 after 5 cycles. Enables remain 0; mem_ready=1 has no effect until rst.
- Saturation: force 70000 stall cycles → stall_cnt holds 16'hFFFF.
